slave_port: RTL and testbench
=============================

Name: slave_port

Overview:
- Serial-bus slave interface that consumes the bit stream produced by a master port after the address decoder has routed it.
- Receives a 12-bit memory address LSB-first, then either receives 8 write-data bits or returns 8 read-data bits.
- Drives a simple parallel memory interface toward the slave device.
- Issues a split request to the arbiter when the read response is slow, so the bus can be released.

Parameters:
- ADDR_WIDTH, 12, slave memory address width (bits received serially).
- DATA_WIDTH, 8, data width.
- SPLIT_EN, 1, 1 enables split on slow reads; 0 waits indefinitely holding the bus.
- SPLIT_THRESHOLD, 4, MEMRD cycles without mem_rvalid before ssplit asserts.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- swdata  input  1  serial write data/address from bus (master mwdata).
- smode  input  1  0 read, 1 write; valid throughout transaction.
- mvalid  input  1  swdata valid this cycle.
- srdata  output  1  serial read data to bus.
- svalid  output  1  srdata valid.
- sready  output  1  high only in IDLE; to decoder.
- ssplit  output  1  split request to arbiter.
- split_grant  input  1  arbiter has re-granted bus to the split master.
- mem_addr  output  ADDR_WIDTH  latched memory address.
- mem_wdata  output  DATA_WIDTH  latched write data.
- mem_wen  output  1  one-cycle write strobe.
- mem_ren  output  1  read request, held until mem_rvalid.
- mem_rdata  input  DATA_WIDTH  read data.
- mem_rvalid  input  1  mem_rdata valid (single-cycle pulse).

Behaviour:
- Reset (async, rstn low): state IDLE. srdata=0, svalid=0, ssplit=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, counter=0. Internal rdata=0.
- Only routed bits are seen: the device-address nibble never reaches this block. All serial fields are LSB-first. A bit is captured only on a clk edge with mvalid=1; mvalid=0 cycles are gaps and hold state/counter.
- IDLE: sready=1. When mvalid=1: capture swdata into addr[0], set counter=1, go to ADDR.
- ADDR: on each mvalid cycle, capture addr[counter] and increment counter. When bit ADDR_WIDTH-1 is captured:
  - update mem_addr and clear counter;
  - if smode=1, latch mode=write and go to WDATA;
  - if smode=0, go to MEMRD.
- WDATA: the master's one-cycle setup gap (mvalid=0) is absorbed by gap rule. On each mvalid cycle, capture wdata[counter]. After bit DATA_WIDTH-1, update mem_wdata and go to MEMWR.
- MEMWR: mem_wen=1 for exactly one cycle, with mem_addr/mem_wdata stable. Next state IDLE.
- MEMRD: mem_ren=1. A wait counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata into rdata, drop mem_ren next cycle, go to RDATA.
  - SPLIT_EN=1 and wait counter reaches SPLIT_THRESHOLD without mem_rvalid: assert ssplit and go to SPLIT; mem_ren stays high.
  - mem_rvalid arriving in the same cycle as the threshold: mem_rvalid wins and no split is issued.
- SPLIT: ssplit=1 and mem_ren=1 until mem_rvalid. On mem_rvalid:
  - capture rdata;
  - drop mem_ren and ssplit on the next edge.
  - Then wait for split_grant=1 and go to RDATA.
  - split_grant seen while ssplit is still 1 is ignored.
- RDATA: drive srdata=rdata[counter] with svalid=1 for DATA_WIDTH consecutive cycles, counter 0..DATA_WIDTH-1. After the last bit, svalid=0 and go to IDLE. srdata holds its last value when svalid=0.
- Back-to-back transactions: IDLE is entered for at least one cycle between transactions (sready pulse).
- Reset mid-transaction aborts immediately to reset values. No memory strobe is issued for a partially received transaction.
- Counters sized ceil(log2(max(ADDR_WIDTH,DATA_WIDTH)))+1. Wait counter saturates at SPLIT_THRESHOLD.

Test Plan:
- Write with a contiguous 12 address bits, a one-cycle gap, then 8 data bits, addr=0x5A3, data=0xC6 -> one mem_wen pulse with mem_addr=0x5A3, mem_wdata=0xC6, then IDLE with sready=1.
- Read addr=0x00F with mem_rvalid 2 cycles after mem_ren and data 0x3B -> ssplit never asserts; svalid high 8 cycles carrying srdata bits 1,1,0,1,1,1,0,0.
- Read, SPLIT_EN=1, THRESHOLD=4, mem_rvalid after 10 cycles with data 0x81 -> ssplit rises after 4 MEMRD cycles and falls after mem_rvalid. No svalid until split_grant; then 8 bits of 0x81 LSB-first.
- Random mvalid gaps inside the address and data fields for addr=0xFFF, data=0x00 -> values captured correctly and exactly one mem_wen.
- rstn pulled low after 6 address bits, then a full write addr=0x123, data=0x55 -> no strobe for the aborted transfer; one correct write afterwards.
- Read with mem_rvalid exactly at the threshold cycle -> no ssplit; immediate 8-bit response.

Source files
------------

// File: rtl/slave_port.sv
// Serial-bus slave: deserialises an LSB-first address and write data, drives a parallel
// memory port, and serialises read data back, optionally splitting the bus on slow reads.
module slave_port #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter bit SPLIT_EN        = 1'b1,
    parameter int SPLIT_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic                  ssplit,
    input  logic                  split_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam int WW   = $clog2(SPLIT_THRESHOLD + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(SPLIT_THRESHOLD);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_MEMWR = 3'd3;
    localparam logic [2:0] S_MEMRD = 3'd4;
    localparam logic [2:0] S_SPLIT = 3'd5;
    localparam logic [2:0] S_GRANT = 3'd6;
    localparam logic [2:0] S_RDATA = 3'd7;

    logic [2:0]            state_q,    state_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [WW-1:0]         waitCnt_q,  waitCnt_d;
    logic [WW-1:0]         waitInc;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic                  srdata_q,   srdata_d;
    logic                  svalid_q,   svalid_d;

    // Serial fields are shifted in from the top so that after a full field the first bit sits at the LSB.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waitCnt_d  = waitCnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        srdata_d   = srdata_q;
        svalid_d   = svalid_q;
        waitInc    = waitCnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (mvalid) begin
                    addr_d  = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d   = CNT_ONE;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mvalid) begin
                    addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        memAddr_d = addr_d;
                        cnt_d     = '0;
                        waitCnt_d = '0;
                        state_d   = smode ? S_WDATA : S_MEMRD;
                    end
                end
            end
            S_WDATA: begin
                if (mvalid) begin
                    wdata_d = {swdata, wdata_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        memWdata_d = wdata_d;
                        cnt_d      = '0;
                        state_d    = S_MEMWR;
                    end
                end
            end
            S_MEMWR: state_d = S_IDLE;
            S_MEMRD: begin
                // A response in the threshold cycle still beats the split.
                if (mem_rvalid) begin
                    srdata_d = mem_rdata[0];
                    rdata_d  = mem_rdata >> 1;
                    svalid_d = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = S_RDATA;
                end else if (waitCnt_q != WAIT_MAX) begin
                    waitCnt_d = waitInc;
                    if (SPLIT_EN && (waitInc == WAIT_MAX)) begin
                        state_d = S_SPLIT;
                    end
                end
            end
            S_SPLIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (split_grant) begin
                    srdata_d = rdata_q[0];
                    rdata_d  = rdata_q >> 1;
                    svalid_d = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = S_RDATA;
                end
            end
            S_RDATA: begin
                if (cnt_q == DATA_BITS) begin
                    svalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    srdata_d = rdata_q[0];
                    rdata_d  = rdata_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            waitCnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            srdata_q   <= 1'b0;
            svalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waitCnt_q  <= waitCnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            srdata_q   <= srdata_d;
            svalid_q   <= svalid_d;
        end
    end

    assign sready    = (state_q == S_IDLE);
    assign mem_wen   = (state_q == S_MEMWR);
    assign mem_ren   = (state_q == S_MEMRD) || (state_q == S_SPLIT);
    assign ssplit    = (state_q == S_SPLIT);
    assign srdata    = srdata_q;
    assign svalid    = svalid_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
endmodule

// File: tb/tb_slave_port.sv
// Randomised self-checking bench for slave_port; expectations come from a
// transaction-level model (strobe list, response bits, mem_ren/ssplit cycle counts).
module tb_slave_port;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int THR = 4;

    logic          clk;
    logic          rstn;
    logic          swdata;
    logic          smode;
    logic          mvalid;
    logic          srdata;
    logic          svalid;
    logic          sready;
    logic          ssplit;
    logic          split_grant;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    int checks = 0;
    int errors = 0;

    int            renCnt = 0;
    int            splitCnt = 0;
    int            svRuns = 0;
    logic          prevSv = 1'b0;
    logic          rxBits[$];
    logic [AW-1:0] wrAddrQ[$];
    logic [DW-1:0] wrDataQ[$];

    int            rdLatency = 0;
    logic [DW-1:0] rdData = '0;
    int            renSeen = 0;
    bit            respDone = 1'b1;

    slave_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SPLIT_EN(1'b1),
        .SPLIT_THRESHOLD(THR)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .swdata(swdata),
        .smode(smode),
        .mvalid(mvalid),
        .srdata(srdata),
        .svalid(svalid),
        .sready(sready),
        .ssplit(ssplit),
        .split_grant(split_grant),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen(mem_wen),
        .mem_ren(mem_ren),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus/memory observer, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ren) renCnt++;
            if (ssplit) splitCnt++;
            if (svalid) rxBits.push_back(srdata);
            if (svalid && !prevSv) svRuns++;
            prevSv = svalid;
            if (mem_wen) begin
                wrAddrQ.push_back(mem_addr);
                wrDataQ.push_back(mem_wdata);
            end
        end
    end

    // Memory model: answers on the rdLatency-th cycle of mem_ren, junk data otherwise.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = DW'($urandom);
            if (mem_ren && !respDone) begin
                renSeen++;
                if (renSeen == rdLatency) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdData;
                    respDone   = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        renCnt   = 0;
        splitCnt = 0;
        svRuns   = 0;
        rxBits.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    // Sends n bits of v LSB-first, optionally with random mvalid gaps.
    task automatic applyStimulus(input logic [15:0] v, input int n, input bit gaps);
        logic [15:0] sh;
        sh = v;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                mvalid = 1'b0;
                swdata = 1'($urandom);
                repeat ($urandom_range(1, 2)) tick();
            end
            mvalid = 1'b1;
            swdata = sh[0];
            sh     = sh >> 1;
            tick();
        end
        mvalid = 1'b0;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit gaps);
        clearMon();
        checkOutput("wrIdleReady", 32'(sready), 32'd1);
        smode = 1'b1;
        applyStimulus(16'(a), AW, gaps);
        tick();
        applyStimulus(16'(d), DW, gaps);
        for (int c = 0; c < 10 && wrAddrQ.size() == 0; c++) tick();
        repeat (3) tick();
        checkOutput("wrStrobes", 32'(wrAddrQ.size()), 32'd1);
        if (wrAddrQ.size() > 0) begin
            checkOutput("wrAddr", 32'(wrAddrQ[0]), 32'(a));
            checkOutput("wrData", 32'(wrDataQ[0]), 32'(d));
        end
        checkOutput("wrBackIdle", 32'(sready), 32'd1);
        checkOutput("wrNoRead", 32'(renCnt), 32'd0);
    endtask

    task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat, input bit gaps);
        bit            sawSplit;
        bit            granted;
        bit            poked;
        int            cycles;
        int            grantWait;
        int            grantDelay;
        int            expSplit;
        logic [DW-1:0] got;
        sawSplit   = 1'b0;
        granted    = 1'b0;
        poked      = 1'b0;
        cycles     = 0;
        grantWait  = 0;
        grantDelay = $urandom_range(0, 3);
        expSplit   = (lat > THR) ? (lat - THR) : 0;
        clearMon();
        rdLatency = lat;
        rdData    = d;
        renSeen   = 0;
        respDone  = 1'b0;
        checkOutput("rdIdleReady", 32'(sready), 32'd1);
        smode = 1'b0;
        applyStimulus(16'(a), AW, gaps);
        while (rxBits.size() < DW && cycles < 300) begin
            tick();
            cycles++;
            split_grant = 1'b0;
            if (ssplit) begin
                sawSplit = 1'b1;
                if (!poked) begin
                    split_grant = 1'b1;
                    poked       = 1'b1;
                end
            end else if (sawSplit && !mem_ren && !granted) begin
                if (grantWait == grantDelay) begin
                    checkOutput("rdNoEarlySvalid", 32'(rxBits.size()), 32'd0);
                    split_grant = 1'b1;
                    granted     = 1'b1;
                end
                grantWait++;
            end
        end
        split_grant = 1'b0;
        checkOutput("rdTimeout", 32'(cycles < 300), 32'd1);
        repeat (3) tick();
        got = '0;
        for (int i = 0; i < rxBits.size() && i < DW; i++) got = {rxBits[i], got[DW-1:1]};
        checkOutput("rdBitCount", 32'(rxBits.size()), 32'(DW));
        checkOutput("rdData", 32'(got), 32'(d));
        checkOutput("rdSvRuns", 32'(svRuns), 32'd1);
        checkOutput("rdRenCycles", 32'(renCnt), 32'(lat));
        checkOutput("rdSplitCycles", 32'(splitCnt), 32'(expSplit));
        checkOutput("rdAddr", 32'(mem_addr), 32'(a));
        checkOutput("rdSvalidLow", 32'(svalid), 32'd0);
        checkOutput("rdSrdataHold", 32'(srdata), 32'(d[DW-1]));
        checkOutput("rdBackIdle", 32'(sready), 32'd1);
        checkOutput("rdNoWrite", 32'(wrAddrQ.size()), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            lat;
        rstn        = 1'b0;
        swdata      = 1'b0;
        smode       = 1'b0;
        mvalid      = 1'b0;
        split_grant = 1'b0;
        repeat (3) tick();
        checkOutput("rstSready", 32'(sready), 32'd1);
        checkOutput("rstSvalid", 32'(svalid), 32'd0);
        checkOutput("rstMemWen", 32'(mem_wen), 32'd0);
        checkOutput("rstMemRen", 32'(mem_ren), 32'd0);
        checkOutput("rstSsplit", 32'(ssplit), 32'd0);
        checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        doWrite(12'hFFF, 8'h00, 1'b1);
        doWrite(12'h5A3, 8'hC6, 1'b0);
        doRead(12'h00F, 8'h3B, 3, 1'b0);
        doRead(12'h7E1, 8'h81, 10, 1'b0);
        doRead(12'h2C4, 8'hA5, THR, 1'b0);

        // Abort a write after six address bits.
        clearMon();
        smode = 1'b1;
        applyStimulus(16'h0123, 6, 1'b0);
        rstn = 1'b0;
        tick();
        checkOutput("abortSready", 32'(sready), 32'd1);
        checkOutput("abortMemAddr", 32'(mem_addr), 32'd0);
        checkOutput("abortMemWdata", 32'(mem_wdata), 32'd0);
        checkOutput("abortSrdata", 32'(srdata), 32'd0);
        checkOutput("abortMemWen", 32'(mem_wen), 32'd0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        checkOutput("abortNoStrobe", 32'(wrAddrQ.size()), 32'd0);
        doWrite(12'h123, 8'h55, 1'b0);

        for (int t = 0; t < 12; t++) begin
            ra  = AW'($urandom);
            rd  = DW'($urandom);
            lat = $urandom_range(1, 9);
            if ($urandom_range(0, 1) == 1) doWrite(ra, rd, 1'($urandom));
            else doRead(ra, rd, lat, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
